// File: rtl/complement_serial.sv
// complement_serial: digit-serial two's-complement unit (negate / absolute / pass).
// Handles DIGIT bits per clock, starting at the LSB. The "first 1 seen" flag is
// carried from one digit to the next, so an operation takes K = WIDTH/DIGIT cycles.
// Optional build macro COMPLEMENT_OVF_EN adds the out_Overflow port. It flags the
// case where the most-negative operand is inverted.
module complement_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_Valid,
  output logic             out_Ready,
  input  logic [1:0]       in_Mode,
  input  logic [WIDTH-1:0] in_Operand,
  output logic             out_Valid,
  input  logic             in_Ack,
  output logic [WIDTH-1:0] out_Result
`ifdef COMPLEMENT_OVF_EN
  ,
  output logic             out_Overflow
`endif
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0]    LAST   = CW'(K - 1);
  localparam logic [WIDTH-1:0] MINNEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             inv_q, inv_d;
  logic             flag_q, flag_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] dig_op, dig_res;
  logic             dig_flag;

  // One digit of the complement. A bit is inverted only when some lower bit was 1.
  always_comb begin
    logic f;
    dig_op  = opnd_q[int'(cnt_q)*DIGIT +: DIGIT];
    dig_res = '0;
    f       = flag_q;
    for (int j = 0; j < DIGIT; j++) begin
      dig_res[j] = (inv_q & f) ? ~dig_op[j] : dig_op[j];
      f          = f | dig_op[j];
    end
    dig_flag = f;
  end

  // FSM next state, datapath next values and handshake outputs.
  always_comb begin
    state_d   = state_q;
    opnd_d    = opnd_q;
    result_d  = result_q;
    inv_d     = inv_q;
    flag_d    = flag_q;
    cnt_d     = cnt_q;
    out_Ready = 1'b0;
    out_Valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        out_Ready = 1'b1;
        if (in_Valid) begin
          opnd_d  = in_Operand;
          // Mode 11 is reserved and runs as pass.
          unique case (in_Mode)
            2'b00:   inv_d = 1'b1;
            2'b01:   inv_d = in_Operand[WIDTH-1];
            default: inv_d = 1'b0;
          endcase
          flag_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        result_d[int'(cnt_q)*DIGIT +: DIGIT] = dig_res;
        flag_d = dig_flag;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        out_Valid = 1'b1;
        if (in_Ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. Reset discards any operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opnd_q   <= '0;
      result_q <= '0;
      inv_q    <= 1'b0;
      flag_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      inv_q    <= inv_d;
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_Result = result_q;

`ifdef COMPLEMENT_OVF_EN
  logic ovf_q;

  // Overflow is cleared when a request is accepted. It is decided on the last digit,
  // so it becomes valid at the same time as out_Valid and is held with the result.
  always_ff @(posedge clock) begin
    if (reset)
      ovf_q <= 1'b0;
    else if (state_q == S_IDLE && in_Valid)
      ovf_q <= 1'b0;
    else if (state_q == S_RUN && cnt_q == LAST)
      ovf_q <= inv_q && (opnd_q == MINNEG);
  end

  assign out_Overflow = ovf_q;
`endif

endmodule
